xgriscv_lsu: RTL and testbench

Load/store unit for the pipelined xgriscv core. It sits between the MEM stage and the data memory port. It converts a load or store request into lane-aligned memory accesses and drives the 4-bit byte-enable (`amp`) and write-data lanes. For loads it collects the memory response, extracts and sign- or zero-extends the result, and stalls the pipeline while any access is outstanding.

---
 rtl/xgriscv_lsu_pkg.sv | 52 +++++
 rtl/xgriscv_lsu_align.sv | 33 +++
 rtl/xgriscv_lsu.sv | 148 ++++++++++++++
 tb/tb_xgriscv_lsu.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/xgriscv_lsu_pkg.sv
// Shared constants for the xgriscv load/store unit: funct3 codes,
// FSM state encodings, access size masks and small decode helpers.
package xgriscv_lsu_pkg;

  // funct3 codes (stores use only the first three)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // access size masks, shifted left by addr[1:0] to form the byte mask
  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0011;
  localparam logic [3:0] SZ_W = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ0 = 3'd1,
    S_RSP0 = 3'd2,
    S_REQ1 = 3'd3,
    S_RSP1 = 3'd4,
    S_RESP = 3'd5
  } lsu_state_e;

  // funct3[1:0] selects the access size
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = SZ_B;
      2'b01:   size_mask = SZ_H;
      2'b10:   size_mask = SZ_W;
      default: size_mask = 4'b0000;
    endcase
  endfunction

  // unsigned loads are only meaningful for loads; 011/11x never legal
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !we;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

  // true when the access spills into the next word
  function automatic logic is_split(input logic [2:0] f3, input logic [1:0] off);
    logic [7:0] m;
    m = {4'b0000, size_mask(f3[1:0])} << off;
    is_split = |m[7:4];
  endfunction

endpackage

// File: rtl/xgriscv_lsu_align.sv
// Combinational lane alignment: byte mask, shifted store data, and
// load extract with sign/zero extension from the two response words.
module xgriscv_lsu_align
  import xgriscv_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic [XLEN-1:0]   wdata,
  input  logic [2*XLEN-1:0] r64_raw,
  output logic [7:0]        m8,
  output logic [2*XLEN-1:0] w64,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] rw;

  // shift masks/data into lanes and pull the addressed bytes down to bit 0
  always_comb begin
    m8  = {4'b0000, size_mask(funct3[1:0])} << off;
    w64 = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
    rw  = XLEN'(r64_raw >> {off, 3'b000});
    case (funct3)
      F3_B:    rdata = {{(XLEN-8){rw[7]}}, rw[7:0]};
      F3_H:    rdata = {{(XLEN-16){rw[15]}}, rw[15:0]};
      F3_BU:   rdata = {{(XLEN-8){1'b0}}, rw[7:0]};
      F3_HU:   rdata = {{(XLEN-16){1'b0}}, rw[15:0]};
      default: rdata = rw;
    endcase
  end

endmodule

// File: rtl/xgriscv_lsu.sv
// Load/store unit: accepts one MEM-stage request at a time, issues one or
// two word accesses and returns the extended load result with a done pulse.
// Define XGRISCV_LSU_MISALIGN_EN to split misaligned accesses in two;
// otherwise they complete with an error and no memory traffic.
module xgriscv_lsu
  import xgriscv_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic            lsu_we,
  input  logic [2:0]      lsu_funct3,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_done,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_err,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_amp,
  output logic [XLEN-1:0] mem_wd,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] rd0_q, rd0_d;
  logic [XLEN-1:0] rd1_q, rd1_d;

  logic [7:0]        m8;
  logic [2*XLEN-1:0] w64;
  logic              second;

  xgriscv_lsu_align #(.XLEN(XLEN)) u_align (
    .funct3  (f3_q),
    .off     (addr_q[1:0]),
    .wdata   (wdata_q),
    .r64_raw ({rd1_q, rd0_q}),
    .m8      (m8),
    .w64     (w64),
    .rdata   (lsu_rdata)
  );

  assign second = (state_q == S_REQ1);

  // next-state and request-side outputs; memory lanes are zero unless requesting
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rd0_d     = rd0_q;
    rd1_d     = rd1_q;
    lsu_ready = 1'b0;
    mem_req   = 1'b0;
    case (state_q)
      S_IDLE: begin
        lsu_ready = 1'b1;
        if (lsu_valid) begin
          we_d    = lsu_we;
          f3_d    = lsu_funct3;
          addr_d  = lsu_addr;
          wdata_d = lsu_wdata;
          rd0_d   = '0;
          rd1_d   = '0;
`ifdef XGRISCV_LSU_MISALIGN_EN
          err_d   = !f3_legal(lsu_we, lsu_funct3);
`else
          err_d   = !f3_legal(lsu_we, lsu_funct3) || is_split(lsu_funct3, lsu_addr[1:0]);
`endif
          state_d = err_d ? S_RESP : S_REQ0;
        end
      end
      S_REQ0: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = S_RSP0;
      end
      S_RSP0: begin
        if (mem_rvalid) begin
          if (!we_q) rd0_d = mem_rdata;
`ifdef XGRISCV_LSU_MISALIGN_EN
          state_d = (|m8[7:4]) ? S_REQ1 : S_RESP;
`else
          state_d = S_RESP;
`endif
        end
      end
`ifdef XGRISCV_LSU_MISALIGN_EN
      S_REQ1: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = S_RSP1;
      end
      S_RSP1: begin
        if (mem_rvalid) begin
          if (!we_q) rd1_d = mem_rdata;
          state_d = S_RESP;
        end
      end
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // second access uses the upper halves of the lane mask/data and the next word
  assign mem_we   = mem_req & we_q;
  assign mem_amp  = mem_req ? (second ? m8[7:4] : m8[3:0]) : 4'b0000;
  assign mem_wd   = mem_req ? (second ? w64[2*XLEN-1:XLEN] : w64[XLEN-1:0]) : '0;
  assign mem_addr = mem_req ? ({addr_q[XLEN-1:2], 2'b00} + {{(XLEN-3){1'b0}}, second, 2'b00}) : '0;
  assign lsu_done = (state_q == S_RESP);
  assign lsu_err  = lsu_done & err_q;

  // state and request registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

endmodule

// File: tb/tb_xgriscv_lsu.sv
// Self-checking bench for xgriscv_lsu: a word memory model with
// programmable grant/response waits, an expected-access queue checked on
// every request cycle, and a completion scoreboard checked on lsu_done.
module tb_xgriscv_lsu;

  logic        clk, rstn;
  logic        lsu_valid, lsu_ready, lsu_we, lsu_done, lsu_err;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wd, mem_rdata;
  logic [3:0]  mem_amp;

  xgriscv_lsu #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_we(lsu_we),
    .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_amp(mem_amp), .mem_wd(mem_wd),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic err; logic ld; logic [31:0] rdata; int lat; string tag; } exp_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] amp; logic [31:0] wd; } acc_t;

  exp_t        sb_q[$];
  acc_t        acc_q[$];
  logic [31:0] mem [int unsigned];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, acc_cyc = 0, done_cnt = 0;
  int gnt_wait = 0, rv_wait = 0, gnt_cnt = 0, rv_cnt = 0;
  logic        got_done = 1'b0, pend = 1'b0;
  logic [31:0] pend_data = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic exp_acc(input logic we, input logic [31:0] addr, input logic [3:0] amp, input logic [31:0] wd);
    acc_t a;
    a.we = we; a.addr = addr; a.amp = amp; a.wd = wd;
    acc_q.push_back(a);
  endtask

  // one clock: sample at negedge, score completions, then drive memory side
  task automatic cycle();
    exp_t e;
    acc_t a;
    int unsigned wi;
    @(negedge clk);
    cyc++;
    if (lsu_done) begin
      done_cnt++;
      got_done = 1'b1;
      if (sb_q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk({e.tag, ".err"}, lsu_err, e.err);
        if (e.ld && !e.err) chk({e.tag, ".rdata"}, lsu_rdata, e.rdata);
        chk({e.tag, ".lat"}, cyc - acc_cyc, e.lat);
      end
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (pend) begin
      if (rv_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = pend_data;
        pend = 1'b0;
      end else rv_cnt--;
    end else if (mem_req) begin
      if (acc_q.size() == 0) chk("unexp_req", 1, 0);
      else begin
        a = acc_q[0];
        chk("m_addr", mem_addr, a.addr);
        chk("m_amp", mem_amp, a.amp);
        chk("m_we", mem_we, a.we);
        if (a.we) chk("m_wd", mem_wd, a.wd);
      end
      if (gnt_cnt == 0) begin
        mem_gnt = 1'b1;
        wi = mem_addr[31:2];
        pend_data = mem.exists(wi) ? mem[wi] : 32'h0;
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_amp[b]) pend_data[8*b +: 8] = mem_wd[8*b +: 8];
          mem[wi] = pend_data;
        end
        pend = 1'b1;
        rv_cnt = rv_wait;
        gnt_cnt = gnt_wait;
        if (acc_q.size() != 0) void'(acc_q.pop_front());
      end else gnt_cnt--;
    end
  endtask

  // issue one request; abort_at > 0 pulses reset that many cycles after accept
  task automatic req(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input int lat, input int abort_at);
    exp_t e;
    int n;
    e.err = exp_err; e.ld = !we; e.rdata = exp_rd; e.lat = lat; e.tag = tag;
    sb_q.push_back(e);
    n = 0;
    while (!lsu_ready && n < 20) begin cycle(); n++; end
    chk({tag, ".rdy_in"}, lsu_ready, 1);
    lsu_valid = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
    acc_cyc = cyc;
    got_done = 1'b0;
    gnt_cnt = gnt_wait;
    for (int k = 1; k <= 40 && !got_done; k++) begin
      cycle();
      if (k == 1) lsu_valid = 1'b0;
      chk({tag, ".rdy_busy"}, lsu_ready, 0);
      if (k == abort_at) begin
        rstn = 1'b0;
        #1;
        chk({tag, ".rst_req"}, mem_req, 0);
        chk({tag, ".rst_rdy"}, lsu_ready, 1);
        chk({tag, ".rst_amp"}, mem_amp, 0);
        chk({tag, ".rst_done"}, lsu_done, 0);
        sb_q.delete();
        acc_q.delete();
        cycle();
        rstn = 1'b1;
        return;
      end
    end
    if (!got_done) chk({tag, ".timeout"}, 0, 1);
    cycle();
    chk({tag, ".rdy_after"}, lsu_ready, 1);
  endtask

  initial begin
    logic [31:0] d, a;
    logic [7:0]  b;
    int          dc;
    rstn = 1'b0; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'b000;
    lsu_addr = '0; lsu_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    mem[32'h200 >> 2] = 32'h80F0_7F01;
    mem[32'h300 >> 2] = 32'h4433_2211;
    mem[32'h304 >> 2] = 32'h8877_6655;
    repeat (2) @(negedge clk);
    chk("rst.ready", lsu_ready, 1);
    chk("rst.done", lsu_done, 0);
    chk("rst.err", lsu_err, 0);
    chk("rst.req", mem_req, 0);
    chk("rst.we", mem_we, 0);
    chk("rst.amp", mem_amp, 0);
    chk("rst.rdata", lsu_rdata, 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.wd", mem_wd, 0);
    rstn = 1'b1;
    cycle();

    // stores, zero-wait memory
    exp_acc(1, 32'h100, 4'b1111, 32'hDEADBEEF);
    req("sw100", 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 3, 0);
    exp_acc(1, 32'h100, 4'b1000, 32'hA500_0000);
    req("sb103", 1, 3'b000, 32'h103, 32'h0000_00A5, 0, 0, 3, 0);
    exp_acc(1, 32'h100, 4'b1100, 32'h1234_0000);
    req("sh102", 1, 3'b001, 32'h102, 32'h0000_1234, 0, 0, 3, 0);
    exp_acc(0, 32'h100, 4'b1111, 32'h0);
    req("lw100", 0, 3'b010, 32'h100, 0, 32'h1234_BEEF, 0, 3, 0);

    // sub-word loads from 0x80F07F01
    exp_acc(0, 32'h200, 4'b0010, 0); req("lb201", 0, 3'b000, 32'h201, 0, 32'h0000_007F, 0, 3, 0);
    exp_acc(0, 32'h200, 4'b1000, 0); req("lb203", 0, 3'b000, 32'h203, 0, 32'hFFFF_FF80, 0, 3, 0);
    exp_acc(0, 32'h200, 4'b1100, 0); req("lhu202", 0, 3'b101, 32'h202, 0, 32'h0000_80F0, 0, 3, 0);
    exp_acc(0, 32'h200, 4'b1100, 0); req("lh202", 0, 3'b001, 32'h202, 0, 32'hFFFF_80F0, 0, 3, 0);

    // illegal funct3: error one cycle after accept, no traffic
    req("ld_f3_011", 0, 3'b011, 32'h200, 0, 0, 1, 1, 0);
    req("ld_f3_111", 0, 3'b111, 32'h200, 0, 0, 1, 1, 0);
    req("st_f3_100", 1, 3'b100, 32'h200, 32'h55, 0, 1, 1, 0);

    // misaligned word load
`ifdef XGRISCV_LSU_MISALIGN_EN
    exp_acc(0, 32'h300, 4'b1110, 0);
    exp_acc(0, 32'h304, 4'b0001, 0);
    req("lw301", 0, 3'b010, 32'h301, 0, 32'h5544_3322, 0, 5, 0);
`else
    req("lw301", 0, 3'b010, 32'h301, 0, 0, 1, 1, 0);
`endif

    // grant held off 4 cycles, response delayed 2
    gnt_wait = 4; rv_wait = 2;
    exp_acc(0, 32'h200, 4'b1111, 0);
    req("lw_wait", 0, 3'b010, 32'h200, 0, 32'h80F0_7F01, 0, 9, 0);

    // reset while waiting in RSP0, then a late rvalid that must be ignored
    gnt_wait = 0; rv_wait = 2;
    exp_acc(0, 32'h200, 4'b1111, 0);
    dc = done_cnt;
    req("lw_rst", 0, 3'b010, 32'h200, 0, 0, 0, 3, 2);
    repeat (5) cycle();
    chk("rst.no_done", done_cnt - dc, 0);
    rv_wait = 0;
    exp_acc(0, 32'h200, 4'b0010, 0);
    req("lb_post_rst", 0, 3'b000, 32'h201, 0, 32'h0000_007F, 0, 3, 0);

    // random aligned round trips plus byte reads per lane
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      a = 32'h400 + 32'(4 * i);
      b = d[8*i +: 8];
      exp_acc(1, a, 4'b1111, d);
      req("sw_rnd", 1, 3'b010, a, d, 0, 0, 3, 0);
      exp_acc(0, a, 4'b1111, 0);
      req("lw_rnd", 0, 3'b010, a, 0, d, 0, 3, 0);
      exp_acc(0, a, 4'b0001 << i, 0);
      req("lbu_rnd", 0, 3'b100, a + 32'(i), 0, {24'h0, b}, 0, 3, 0);
      exp_acc(0, a, 4'b0001 << i, 0);
      req("lb_rnd", 0, 3'b000, a + 32'(i), 0, {{24{b[7]}}, b}, 0, 3, 0);
    end

    repeat (3) cycle();
    chk("sb_empty", sb_q.size(), 0);
    chk("acc_empty", acc_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
